// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the RA/RB ALU control path: opcode values,
// instruction word field positions and the sequencer state encoding.
package alu_ctrl_pkg;

    // Opcodes forwarded to the datapath output-select decoder
    localparam logic [2:0] OP_XOR  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_MOV  = 3'b010;
    localparam logic [2:0] OP_EXCH = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    // Instruction word layout: [7]=HALT, [6:3]=repeat count, [2:0]=opcode
    localparam int HALT_BIT = 7;
    localparam int REP_MSB  = 6;
    localparam int REP_LSB  = 3;
    localparam int OP_MSB   = 2;
    localparam int OP_LSB   = 0;
    localparam int REP_W    = REP_MSB - REP_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer for the two-register ALU datapath. Fetches 8-bit
// instruction words, drives the opcode onto sel, and writes the decoder's
// outA/outB back into RA/RB, repeating each instruction R+1 times until a
// HALT word is fetched.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] ra_init,
    input  logic [DATA_W-1:0] rb_init,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    output logic [2:0]        sel,
    input  logic [DATA_W-1:0] dp_a,
    input  logic [DATA_W-1:0] dp_b,
    output logic [DATA_W-1:0] ra,
    output logic [DATA_W-1:0] rb,
    output logic              busy,
    output logic              done,
    output logic [15:0]       op_count
);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [2:0]        op_q;
    logic [REP_W-1:0]  rep_q;
    logic [2:0]        sel_q;
    logic [DATA_W-1:0] ra_q;
    logic [DATA_W-1:0] rb_q;
    logic              done_q;
    logic [15:0]       cnt_q;
    logic [15:0]       cnt_d;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Next PC wraps modulo 2^ADDR_W; op count sticks at its maximum
    always_comb begin
        pc_d  = pc_q + ADDR_W'(1);
        cnt_d = sat_inc16(cnt_q);
    end

    // Sequencer FSM together with all architectural and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            op_q    <= '0;
            rep_q   <= '0;
            sel_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc_q    <= start_addr;
                        ra_q    <= ra_init;
                        rb_q    <= rb_init;
                        cnt_q   <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        op_q  <= imem_data[OP_MSB:OP_LSB];
                        rep_q <= imem_data[REP_MSB:REP_LSB];
                        if (imem_data[HALT_BIT]) begin
                            // done is registered, so raise it on entry to DONE
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // sel changes here so the datapath has all of WB to settle
                    sel_q   <= op_q;
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    ra_q  <= dp_a;
                    rb_q  <= dp_b;
                    cnt_q <= cnt_d;
                    if (rep_q == '0) begin
                        pc_q    <= pc_d;
                        state_q <= ST_FETCH;
                    end else begin
                        rep_q   <= rep_q - REP_W'(1);
                        state_q <= ST_EXEC;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == ST_FETCH);
    assign busy      = (state_q != ST_IDLE);
    assign imem_addr = pc_q;
    assign sel       = sel_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign done      = done_q;
    assign op_count  = cnt_q;

endmodule
